// File: rtl/updown_arbiter.sv
// Round-robin arbiter stepping a shared up/down count register, one step per grant.
// Optional grant statistics (up_cnt/dn_cnt) enabled by defining UPDOWN_ARB_STATS_EN.
//
// state | meaning
// IDLE  | accepts load or arbitrates pending requests
// GAP   | one-cycle recovery after a grant, requests ignored, busy=1
module updown_arbiter #(
  parameter int WIDTH        = 3,
  parameter int WRAP         = 0,
  parameter int LOAD_DEFAULT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_up,
  input  logic             req_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             gnt_up,
  output logic             gnt_dn,
  output logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             busy
`ifdef UPDOWN_ARB_STATS_EN
  ,
  output logic [7:0]       up_cnt,
  output logic [7:0]       dn_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] MIN_VAL  = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(LOAD_DEFAULT);
  localparam bit               SATURATE = (WRAP == 0);

  state_t           state_q, state_d;
  logic             ptr_dn_q, ptr_dn_d;  // 0: up side wins a tie
  logic             win_up, win_dn;
  logic             sat_d;
  logic [WIDTH-1:0] count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_dn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_dn_q <= ptr_dn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!load && (req_up || req_dn)) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load is evaluated before arbitration, so it suppresses any grant that cycle.
  always_comb begin
    win_up   = 1'b0;
    win_dn   = 1'b0;
    sat_d    = 1'b0;
    count_d  = count;
    ptr_dn_d = ptr_dn_q;
    if (load) begin
      count_d = load_val;
    end else if (state_q == IDLE) begin
      if (req_up && (!req_dn || !ptr_dn_q)) win_up = 1'b1;
      else if (req_dn)                      win_dn = 1'b1;
      if (win_up) begin
        ptr_dn_d = 1'b1;
        if (SATURATE && count == MAX_VAL) sat_d = 1'b1;
        else count_d = count + ONE;
      end
      if (win_dn) begin
        ptr_dn_d = 1'b0;
        if (SATURATE && count == MIN_VAL) sat_d = 1'b1;
        else count_d = count - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= RST_VAL;
      gnt_up <= 1'b0;
      gnt_dn <= 1'b0;
      sat    <= 1'b0;
    end else begin
      count  <= count_d;
      gnt_up <= win_up;
      gnt_dn <= win_dn;
      sat    <= sat_d;
    end
  end

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == MIN_VAL);
  assign busy   = (state_q == GAP);

`ifdef UPDOWN_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_cnt <= 8'd0;
      dn_cnt <= 8'd0;
    end else if (load) begin
      up_cnt <= 8'd0;
      dn_cnt <= 8'd0;
    end else begin
      if (win_up && up_cnt != 8'hFF) up_cnt <= up_cnt + 8'd1;
      if (win_dn && dn_cnt != 8'hFF) dn_cnt <= dn_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_updown_arbiter.sv
// Directed bench: a saturating (u0) and a wrapping (u1) arbiter share one stimulus stream.
module tb_updown_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_up, req_dn, load;
  logic [2:0] load_val;
  logic       g0_up, g0_dn, s0, mx0, mn0, b0;
  logic       g1_up, g1_dn, s1, mx1, mn1, b1;
  logic [2:0] c0, c1;
`ifdef UPDOWN_ARB_STATS_EN
  logic [7:0] uc0, dc0, uc1, dc1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  updown_arbiter #(.WIDTH(3), .WRAP(0), .LOAD_DEFAULT(0)) u0 (
    .clk(clk), .reset(reset), .req_up(req_up), .req_dn(req_dn), .load(load),
    .load_val(load_val), .gnt_up(g0_up), .gnt_dn(g0_dn), .sat(s0), .count(c0),
    .at_max(mx0), .at_min(mn0), .busy(b0)
`ifdef UPDOWN_ARB_STATS_EN
    , .up_cnt(uc0), .dn_cnt(dc0)
`endif
  );

  updown_arbiter #(.WIDTH(3), .WRAP(1), .LOAD_DEFAULT(0)) u1 (
    .clk(clk), .reset(reset), .req_up(req_up), .req_dn(req_dn), .load(load),
    .load_val(load_val), .gnt_up(g1_up), .gnt_dn(g1_dn), .sat(s1), .count(c1),
    .at_max(mx1), .at_min(mn1), .busy(b1)
`ifdef UPDOWN_ARB_STATS_EN
    , .up_cnt(uc1), .dn_cnt(dc1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_up = 1'b0; req_dn = 1'b0; load = 1'b0; load_val = 3'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (c0 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", c0); end
    checks++; if (mn0 !== 1'b1) begin errors++; $display("FAIL reset_at_min got %0b expected 1", mn0); end
    checks++; if (mx0 !== 1'b0) begin errors++; $display("FAIL reset_at_max got %0b expected 0", mx0); end
    checks++; if ({g0_up, g0_dn, s0} !== 3'b000) begin errors++; $display("FAIL reset_gnt_sat got %b expected 000", {g0_up, g0_dn, s0}); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", b0); end
  endtask

  task automatic test_tie();
    logic [2:0] exp_c;
    logic       exp_up, exp_dn;
    do_load(3'd3);
    checks++; if (c0 !== 3'd3) begin errors++; $display("FAIL tie_load got %0d expected 3", c0); end
    req_up = 1'b1; req_dn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_up = (i % 4 == 0);
      exp_dn = (i % 4 == 2);
      exp_c  = (i % 4 < 2) ? 3'd4 : 3'd3;
      checks++; if ({g0_up, g0_dn} !== {exp_up, exp_dn}) begin errors++; $display("FAIL tie_gnt[%0d] got %b expected %b", i, {g0_up, g0_dn}, {exp_up, exp_dn}); end
      checks++; if (c0 !== exp_c) begin errors++; $display("FAIL tie_count[%0d] got %0d expected %0d", i, c0, exp_c); end
      checks++; if (b0 !== (i % 2 == 0)) begin errors++; $display("FAIL tie_busy[%0d] got %0b expected %0b", i, b0, (i % 2 == 0)); end
    end
    req_up = 1'b0; req_dn = 1'b0;
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_val = 3'd5; req_up = 1'b1;
    tick();
    load = 1'b0;
    checks++; if (c0 !== 3'd5) begin errors++; $display("FAIL loadpri_count got %0d expected 5", c0); end
    checks++; if ({g0_up, g0_dn} !== 2'b00) begin errors++; $display("FAIL loadpri_nognt got %b expected 00", {g0_up, g0_dn}); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL loadpri_busy got %0b expected 0", b0); end
    tick();
    checks++; if (g0_up !== 1'b1) begin errors++; $display("FAIL loadpri_gnt got %0b expected 1", g0_up); end
    checks++; if (c0 !== 3'd6) begin errors++; $display("FAIL loadpri_next got %0d expected 6", c0); end
    req_up = 1'b0;
    tick();
  endtask

  task automatic test_up_sat();
    logic [2:0] e0, e1;
    do_load(3'd0);
    for (int i = 1; i <= 8; i++) begin
      req_up = 1'b1;
      tick();
      e0 = (i == 8) ? 3'd7 : 3'(i);
      e1 = 3'(i);
      checks++; if ({g0_up, g0_dn} !== 2'b10) begin errors++; $display("FAIL up_gnt[%0d] got %b expected 10", i, {g0_up, g0_dn}); end
      checks++; if (c0 !== e0) begin errors++; $display("FAIL up_count[%0d] got %0d expected %0d", i, c0, e0); end
      checks++; if (s0 !== (i == 8)) begin errors++; $display("FAIL up_sat[%0d] got %0b expected %0b", i, s0, (i == 8)); end
      checks++; if (c1 !== e1 || s1 !== 1'b0) begin errors++; $display("FAIL wrap_up[%0d] got %0d/%0b expected %0d/0", i, c1, s1, e1); end
      req_up = 1'b0;
      tick();
      checks++; if ({g0_up, s0} !== 2'b00) begin errors++; $display("FAIL up_gap[%0d] got %b expected 00", i, {g0_up, s0}); end
    end
    checks++; if (mx0 !== 1'b1) begin errors++; $display("FAIL up_at_max got %0b expected 1", mx0); end
  endtask

  task automatic test_wrap();
    do_load(3'd0);
    req_dn = 1'b1;
    tick();
    req_dn = 1'b0;
    checks++; if (c1 !== 3'd7 || s1 !== 1'b0 || g1_dn !== 1'b1) begin errors++; $display("FAIL wrap_dn got count=%0d sat=%0b gnt=%0b expected 7/0/1", c1, s1, g1_dn); end
    checks++; if (mx1 !== 1'b1) begin errors++; $display("FAIL wrap_at_max got %0b expected 1", mx1); end
    checks++; if (c0 !== 3'd0 || s0 !== 1'b1 || g0_dn !== 1'b1) begin errors++; $display("FAIL dn_sat got count=%0d sat=%0b gnt=%0b expected 0/1/1", c0, s0, g0_dn); end
    tick();
    req_up = 1'b1;
    tick();
    req_up = 1'b0;
    checks++; if (c1 !== 3'd0 || s1 !== 1'b0 || g1_up !== 1'b1) begin errors++; $display("FAIL wrap_up0 got count=%0d sat=%0b gnt=%0b expected 0/0/1", c1, s1, g1_up); end
    checks++; if (c0 !== 3'd1 || s0 !== 1'b0) begin errors++; $display("FAIL sat_up1 got count=%0d sat=%0b expected 1/0", c0, s0); end
    tick();
  endtask

  task automatic test_reset_midop();
    do_load(3'd2);
    req_up = 1'b1;
    tick();
    req_up = 1'b0;
    checks++; if (c0 !== 3'd3 || b0 !== 1'b1) begin errors++; $display("FAIL midop_pre got count=%0d busy=%0b expected 3/1", c0, b0); end
    #2 reset = 1'b0;
    #1;
    checks++; if (c0 !== 3'd0) begin errors++; $display("FAIL midop_count got %0d expected 0", c0); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL midop_busy got %0b expected 0", b0); end
    checks++; if ({g0_up, g0_dn, s0} !== 3'b000) begin errors++; $display("FAIL midop_gnt got %b expected 000", {g0_up, g0_dn, s0}); end
`ifdef UPDOWN_ARB_STATS_EN
    checks++; if (uc0 !== 8'd0) begin errors++; $display("FAIL midop_up_cnt got %0d expected 0", uc0); end
`endif
    tick();
    reset = 1'b1;
    tick();
    checks++; if ({g0_up, g0_dn} !== 2'b00 || c0 !== 3'd0) begin errors++; $display("FAIL midop_noreplay got gnt=%b count=%0d expected 00/0", {g0_up, g0_dn}, c0); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_load_priority();
    test_up_sat();
    test_wrap();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_arbiter.md
Name: updown_arbiter

Overview:
- Arbitrates a single shared WIDTH-bit up/down count register between two requesters, "up" and "down".
- Each granted request moves the count by one step in the requester's direction.
- Sits in front of the up/down counter datapath. It replaces the counter's free-running toggle with one step per granted request, gated by the controller.
- Fair round-robin arbitration, saturate-or-wrap boundary policy, and a synchronous load port for initialisation.

Parameters:
- WIDTH, 3, count register width in bits (≥2).
- WRAP, 0, 1 = modulo wrap at the boundaries; 0 = saturate at 0 and 2^WIDTH-1.
- LOAD_DEFAULT, 0, count value forced by reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_up  in  1  up requester asserts; holds high until gnt_up seen.
- req_dn  in  1  down requester asserts; holds high until gnt_dn seen.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value written on load.
- gnt_up  out  1  one-cycle grant pulse to the up requester.
- gnt_dn  out  1  one-cycle grant pulse to the down requester.
- sat  out  1  one-cycle pulse alongside a grant that hit a boundary while WRAP=0 (count unchanged).
- count  out  WIDTH  current count value.
- at_max  out  1  count == 2^WIDTH-1 (combinational from count).
- at_min  out  1  count == 0 (combinational from count).
- busy  out  1  high while the FSM is in GAP.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=LOAD_DEFAULT; gnt_up=gnt_dn=sat=0; busy=0.
  - State=IDLE; round-robin pointer=UP (up side wins the first tie).
- All registered outputs update on posedge clk only. Grants and count are registered.
- FSM states:
  - IDLE: if load=1, count<=load_val, no grant, stay IDLE. Otherwise, if any req is high, pick a winner, pulse its gnt next cycle, update count on the same edge, and go to GAP.
  - GAP: exactly one cycle. No grants issued; busy=1. Requests sampled during GAP are ignored; requesters must drop req in the cycle after their gnt. A load in GAP is applied (count<=load_val). Always returns to IDLE.
- Arbitration:
  - Only one request high: that requester wins.
  - Both high: the side indicated by the pointer wins.
  - After any grant, the pointer moves to the other side.
  - Load does not move the pointer.
- Grant timing:
  - Request sampled high at edge N while in IDLE → gnt and the new count both visible after edge N (cycle N+1).
  - Next grant no earlier than edge N+2. Maximum throughput is one grant per two cycles.
- Arithmetic:
  - Up grant: count+1. Down grant: count-1. Both are WIDTH-bit.
  - WRAP=1: 2^WIDTH-1 → 0 on up, 0 → 2^WIDTH-1 on down; sat is never asserted.
  - WRAP=0: an up grant at max, or a down grant at min, is still granted (handshake completes), count holds, and sat pulses together with gnt.
- Simultaneous events:
  - load and req high together in IDLE: load wins, no grant, request stays pending and is served in a later IDLE cycle.
  - load in the same cycle as an arbitration decision cannot occur; load is checked first.
- Reset mid-operation: an asynchronous reset during GAP, or with a grant pulse high, clears everything immediately. The dropped grant is not replayed; the requester must re-request.
- gnt_up and gnt_dn are never high in the same cycle. sat is only ever high together with exactly one gnt.

Optional Feature:
- Macro UPDOWN_ARB_STATS_EN.
- When defined, adds two outputs: up_cnt[7:0] and dn_cnt[7:0].
  - Each counts grants issued to its side, including saturated grants.
  - Both saturate at 255 and reset to 0.
  - Both are cleared synchronously when load=1 is accepted.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, WIDTH=3, WRAP=0: release reset → count=0, at_min=1, gnt_up=gnt_dn=sat=0, busy=0.
- Up requests, WRAP=0: req_up held, dropped after each gnt, 8 times from count=0 → count steps 1..7 with one grant every 2 cycles. The 8th grant has sat=1, count stays 7, at_max=1.
- Tie, WIDTH=3: req_up and req_dn held high continuously from count=3 → grants alternate up, dn, up, dn, starting with up. count sequence 4,3,4,3. Never both grants in the same cycle.
- Wrap, WRAP=1: load_val=0, load pulse, then one req_dn → count=7, sat=0. Then one req_up → count=0.
- Load priority: load=1, load_val=5 and req_up=1 in the same IDLE cycle → count=5, no gnt. On the next IDLE cycle gnt_up=1 and count=6.
- Reset mid-op: assert reset in the GAP cycle after a grant → count=LOAD_DEFAULT immediately, busy=0. With UPDOWN_ARB_STATS_EN defined, up_cnt=0.
